plab5_mcore_mem_resp_net_arb: RTL and testbench

//  Shares one response-network injection port among p_num_ports memory-bank

---
 rtl/plab5_mcore_mem_resp_net_arb.sv | 133 +++++++++++++
 tb/tb_plab5_mcore_mem_resp_net_arb.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/plab5_mcore_mem_resp_net_arb.sv
// Memory-response network arbiter: N bank adapters share one injection port.
// Round-robin (mode=0) or domain time-sliced (mode=1); one-entry output buffer.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   mode              0=round-robin, 1=domain time-slicing
//   in_val/in_rdy     per-requester handshake (in_rdy one-hot or zero)
//   in_domain         per-requester domain bit
//   in_msg_control    packed control, requester i at [i*C +: C]
//   in_msg_data       packed data, requester i at [i*D +: D]
//   out_val/out_rdy   output handshake
//   out_domain        domain of the buffered message
//   out_msg_control   buffered control
//   out_msg_data      buffered data
//   slot_domain       domain owning the current slot
module plab5_mcore_mem_resp_net_arb #(
  parameter int p_num_ports   = 4,
  parameter int p_ctrl_nbits  = 25,
  parameter int p_data_nbits  = 32,
  parameter int p_slot_cycles = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                mode,
  input  logic [p_num_ports-1:0]              in_val,
  output logic [p_num_ports-1:0]              in_rdy,
  input  logic [p_num_ports-1:0]              in_domain,
  input  logic [p_num_ports*p_ctrl_nbits-1:0] in_msg_control,
  input  logic [p_num_ports*p_data_nbits-1:0] in_msg_data,
  output logic                                out_val,
  input  logic                                out_rdy,
  output logic                                out_domain,
  output logic [p_ctrl_nbits-1:0]             out_msg_control,
  output logic [p_data_nbits-1:0]             out_msg_data,
  output logic                                slot_domain
);

  localparam int N  = p_num_ports;
  localparam int C  = p_ctrl_nbits;
  localparam int D  = p_data_nbits;
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = $clog2(p_slot_cycles);

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] gnt_idx;
  logic [PW-1:0] rr_nxt;
  logic [SW-1:0] slot_cnt;
  logic [N-1:0]  elig;
  logic [N-1:0]  grant;
  logic [C-1:0]  sel_ctrl;
  logic [D-1:0]  sel_data;
  logic          sel_dom;
  logic          found;
  logic          full;
  logic          buf_domain;
  logic [C-1:0]  buf_ctrl;
  logic [D-1:0]  buf_data;
  logic          pres;
  logic          ld;
  logic          xfer;
  logic          slot_wrap;

  always_comb begin
    if (mode) elig = in_val & ~(in_domain ^ {N{slot_domain}});
    else      elig = in_val;
  end

  // Scan rr_ptr, rr_ptr+1, ... mod N; first eligible wins.
  always_comb begin
    int idx;
    idx      = 0;
    grant    = '0;
    gnt_idx  = '0;
    found    = 1'b0;
    sel_ctrl = '0;
    sel_data = '0;
    sel_dom  = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && elig[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gnt_idx    = PW'(idx);
        sel_ctrl   = in_msg_control[idx*C +: C];
        sel_data   = in_msg_data[idx*D +: D];
        sel_dom    = in_domain[idx];
      end
    end
  end

  assign rr_nxt = (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + PW'(1);

  assign pres = full && (!mode || (buf_domain == slot_domain));
  assign ld   = !full || (pres && out_rdy);
  assign in_rdy = reset ? '0 : (grant & {N{ld}});
  assign xfer = |in_rdy;
  assign slot_wrap = (slot_cnt == SW'(p_slot_cycles - 1));

  assign out_val         = pres;
  assign out_domain      = buf_domain;
  assign out_msg_control = buf_ctrl;
  assign out_msg_data    = buf_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cnt    <= '0;
      slot_domain <= 1'b0;
      rr_ptr      <= '0;
      full        <= 1'b0;
      buf_domain  <= 1'b0;
      buf_ctrl    <= '0;
      buf_data    <= '0;
    end else begin
      if (slot_wrap) begin
        slot_cnt    <= '0;
        slot_domain <= !slot_domain;
      end else begin
        slot_cnt <= slot_cnt + SW'(1);
      end
      if (xfer) begin
        full       <= 1'b1;
        buf_domain <= sel_dom;
        buf_ctrl   <= sel_ctrl;
        buf_data   <= sel_data;
        rr_ptr     <= rr_nxt;
      end else if (pres && out_rdy) begin
        full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_plab5_mcore_mem_resp_net_arb.sv
// Directed bench for plab5_mcore_mem_resp_net_arb.
// Grants checked per cycle; delivered messages checked via scoreboard queue.
module tb_plab5_mcore_mem_resp_net_arb;

  localparam int N = 4;
  localparam int C = 25;
  localparam int D = 32;
  localparam int S = 8;

  typedef struct packed {
    logic [C-1:0] c;
    logic [D-1:0] d;
    logic         dom;
  } exp_t;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           mode = 1'b0;
  logic [N-1:0]   in_val = '0;
  logic [N-1:0]   in_rdy;
  logic [N-1:0]   in_domain = '0;
  logic [N*C-1:0] in_msg_control;
  logic [N*D-1:0] in_msg_data;
  logic           out_val;
  logic           out_rdy = 1'b1;
  logic           out_domain;
  logic [C-1:0]   out_msg_control;
  logic [D-1:0]   out_msg_data;
  logic           slot_domain;

  logic [C-1:0] ctrl_t [N];
  logic [D-1:0] data_t [N];
  exp_t q [$];
  int n_assert = 0;
  int n_fail = 0;
  int cyc_n = 0;

  plab5_mcore_mem_resp_net_arb #(
    .p_num_ports(N), .p_ctrl_nbits(C),
    .p_data_nbits(D), .p_slot_cycles(S)
  ) dut (
    .clk(clk), .reset(reset), .mode(mode),
    .in_val(in_val), .in_rdy(in_rdy),
    .in_domain(in_domain),
    .in_msg_control(in_msg_control),
    .in_msg_data(in_msg_data),
    .out_val(out_val), .out_rdy(out_rdy),
    .out_domain(out_domain),
    .out_msg_control(out_msg_control),
    .out_msg_data(out_msg_data),
    .slot_domain(slot_domain)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      in_msg_control[i*C +: C] = ctrl_t[i];
      in_msg_data[i*D +: D]    = data_t[i];
    end
  end

  function automatic void chk(string tag, logic [63:0] obs,
                              logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endfunction

  task automatic set_msgs(input int tag);
    for (int i = 0; i < N; i++) begin
      ctrl_t[i] = C'(i * 256 + tag);
      data_t[i] = 32'hD000_0000 + D'(i * 4096 + tag);
    end
  endtask

  // Scoreboard: pop on every output fire.
  always @(negedge clk) begin
    if (!reset && out_val && out_rdy) begin
      chk("sb_nonempty", 64'(q.size() > 0), 64'd1);
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        chk("out_ctrl", 64'(out_msg_control), 64'(e.c));
        chk("out_data", 64'(out_msg_data), 64'(e.d));
        chk("out_dom", 64'(out_domain), 64'(e.dom));
      end
    end
  end

  // One cycle: check grant, out_val and slot owner at negedge;
  // push the expected message of the expected grantee.
  task automatic cyc(input logic [N-1:0] exp_rdy, input logic exp_ov);
    logic exp_sd;
    @(negedge clk);
    exp_sd = 1'(((cyc_n / S) % 2));
    chk("in_rdy", 64'(in_rdy), 64'(exp_rdy));
    chk("out_val", 64'(out_val), 64'(exp_ov));
    chk("slot_dom", 64'(slot_domain), 64'(exp_sd));
    for (int i = 0; i < N; i++)
      if (exp_rdy[i])
        q.push_back('{c: ctrl_t[i], d: data_t[i], dom: in_domain[i]});
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    chk("rst_in_rdy", 64'(in_rdy), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
    cyc_n = 0;
    #1;
    chk("rst_out_val", 64'(out_val), 64'd0);
    chk("rst_out_dom", 64'(out_domain), 64'd0);
    chk("rst_out_ctrl", 64'(out_msg_control), 64'd0);
    chk("rst_out_data", 64'(out_msg_data), 64'd0);
    chk("rst_slot_dom", 64'(slot_domain), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    set_msgs(0);
    @(posedge clk);
    #1;
    do_reset();

    // Round-robin with all requesters active, pass-through.
    in_val = 4'b1111;
    set_msgs(10); cyc(4'b0001, 1'b0);
    set_msgs(11); cyc(4'b0010, 1'b1);
    set_msgs(12); cyc(4'b0100, 1'b1);
    set_msgs(13); cyc(4'b1000, 1'b1);
    set_msgs(14); cyc(4'b0001, 1'b1);
    in_val = '0;
    cyc('0, 1'b1);
    cyc('0, 1'b0);

    // Single requester, output stall for 3 cycles.
    in_val = 4'b0100;
    out_rdy = 1'b0;
    set_msgs(20); cyc(4'b0100, 1'b0);
    set_msgs(21);
    for (int j = 0; j < 3; j++) begin
      chk("stall_ctrl", 64'(out_msg_control), 64'(C'(2 * 256 + 20)));
      chk("stall_data", 64'(out_msg_data), 64'(32'hD000_2014));
      cyc('0, 1'b1);
    end
    out_rdy = 1'b1;
    cyc(4'b0100, 1'b1);
    in_val = '0;
    cyc('0, 1'b1);
    cyc('0, 1'b0);

    // Bring rr_ptr to 2, then alternate 3,1,3.
    in_val = 4'b0010;
    set_msgs(30); cyc(4'b0010, 1'b0);
    in_val = 4'b1010;
    set_msgs(31); cyc(4'b1000, 1'b1);
    set_msgs(32); cyc(4'b0010, 1'b1);
    set_msgs(33); cyc(4'b1000, 1'b1);
    in_val = '0;
    cyc('0, 1'b1);
    cyc('0, 1'b0);

    // Reset while full and stalled.
    in_val = 4'b0010;
    out_rdy = 1'b0;
    set_msgs(40); cyc(4'b0010, 1'b0);
    cyc('0, 1'b1);
    in_val = 4'b1010;
    do_reset();
    set_msgs(41); cyc(4'b0010, 1'b0);
    in_val = '0;
    out_rdy = 1'b1;
    cyc('0, 1'b1);
    for (int j = 0; j < 14; j++) cyc('0, 1'b0);

    // Time-sliced: domain-1 request waits for slot 1.
    mode = 1'b1;
    in_val = '0;
    do_reset();
    in_val = 4'b0001;
    in_domain = 4'b0001;
    set_msgs(50);
    for (int j = 0; j < 8; j++) cyc('0, 1'b0);
    cyc(4'b0001, 1'b0);
    in_val = '0;
    cyc('0, 1'b1);
    cyc('0, 1'b0);

    // Time-sliced: domain-0 message held across the domain-1 slot.
    in_domain = '0;
    out_rdy = 1'b0;
    do_reset();
    for (int j = 0; j < 7; j++) cyc('0, 1'b0);
    in_val = 4'b0001;
    set_msgs(60); cyc(4'b0001, 1'b0);
    in_val = '0;
    out_rdy = 1'b1;
    for (int j = 0; j < 8; j++) cyc('0, 1'b0);
    cyc('0, 1'b1);
    cyc('0, 1'b0);

    chk("sb_drained", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
